// File: rtl/qkd_sifter_pkg.sv
// Shared definitions for the QKD pair sifter: FSM states, sift outcomes,
// basis-LFSR feedback taps and the per-round sifting decision.
package qkd_sifter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      SETTLE = 3'd2,
      READ   = 3'd3,
      EVAL   = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      KEEP    = 2'd0,
      DISCARD = 2'd1,
      TAMPER  = 2'd2
   } sift_result_t;

   // Bits 15,13,12,10 of a left-shifting register realise x^16+x^14+x^13+x^11+1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic sift_result_t sift_decide(input logic       i_va,
                                                input logic       i_vb,
                                                input logic [7:0] i_a,
                                                input logic [7:0] i_b);
      sift_result_t w_res;
      w_res = DISCARD;
      if (i_va && i_vb) begin
         if (i_a == i_b) w_res = KEEP;
         else            w_res = TAMPER;
      end
      return w_res;
   endfunction

endpackage

// File: rtl/qkd_basis_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying the basis guesses; only the
// low nibble leaves the block because that is all the sifter consumes.
module qkd_basis_lfsr
   import qkd_sifter_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   output logic [3:0] o_bits
);

   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign o_bits = r_lfsr[3:0];

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_lfsr <= SEED;
      else            r_lfsr <= {r_lfsr[14:0], w_fb};
   end

endmodule

// File: rtl/qkd_pair_sifter.sv
// Session controller: runs init/settle/read/eval rounds against one entangled
// pair, sifts matching reads into the key and flags tamper or budget exhaustion.
module qkd_pair_sifter
   import qkd_sifter_pkg::*;
#(
   parameter int          KEY_BITS       = 32,
   parameter int          BITS_PER_ROUND = 1,
   parameter int          MAX_ROUNDS     = 1024,
   parameter logic [15:0] SEED           = 16'hACE1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   output logic                pair_init,
   output logic                pair_read_A,
   output logic                pair_read_B,
   output logic [1:0]          pair_basis_A,
   output logic [1:0]          pair_basis_B,
   input  logic [7:0]          pair_out_A,
   input  logic [7:0]          pair_out_B,
   input  logic                pair_valid_A,
   input  logic                pair_valid_B,
   input  logic                pair_fuse_fire,
   output logic [KEY_BITS-1:0] key,
   output logic                key_valid,
   output logic                busy,
   output logic                err_tamper,
   output logic                err_exhausted,
   output logic [15:0]         rounds_used,
   output logic [15:0]         discard_count,
   output logic [3:0]          dbg_status
);

   localparam int BW = $clog2(KEY_BITS + 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [KEY_BITS-1:0] r_key;
   logic [BW-1:0]       r_bit_cnt;
   logic [15:0]         r_rounds;
   logic [15:0]         r_disc;
   logic                r_tamper;
   logic                r_exh;
   logic [1:0]          r_basis_a;
   logic [1:0]          r_basis_b;
   logic [7:0]          r_cap_a;
   logic [7:0]          r_cap_b;
   logic                r_cap_va;
   logic                r_cap_vb;
   logic                r_cap_fuse;

   logic [3:0]          w_lfsr_bits;
   sift_result_t        w_sift;
   logic [BW-1:0]       w_bit_cnt_keep;
   logic                w_key_full;
   logic                w_budget_out;
   logic                w_start_go;
   logic [KEY_BITS-1:0] w_key_shift;

   qkd_basis_lfsr #(.SEED(SEED)) u_lfsr (
      .i_clk     (clk),
      .i_reset_n (reset),
      .o_bits    (w_lfsr_bits)
   );

   assign w_sift         = sift_decide(r_cap_va, r_cap_vb, r_cap_a, r_cap_b);
   assign w_bit_cnt_keep = r_bit_cnt + BW'(BITS_PER_ROUND);
   assign w_key_full     = (w_sift == KEEP) && (w_bit_cnt_keep == BW'(KEY_BITS));
   assign w_budget_out   = (r_rounds == 16'(MAX_ROUNDS));
   assign w_key_shift    = (r_key << BITS_PER_ROUND) | KEY_BITS'(r_cap_a[BITS_PER_ROUND-1:0]);
   assign w_start_go     = start && !abort &&
                           (r_state == IDLE || r_state == DONE || r_state == ERROR);

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = INIT;
         INIT:    w_state_next = SETTLE;
         SETTLE:  w_state_next = READ;
         READ:    w_state_next = EVAL;
         EVAL: begin
            if (w_sift == TAMPER) w_state_next = ERROR;
            else if (w_key_full)  w_state_next = DONE;
            else if (w_budget_out) w_state_next = ERROR;
            else                  w_state_next = INIT;
         end
         DONE:    if (start) w_state_next = INIT;
         ERROR:   if (start) w_state_next = INIT;
         default: w_state_next = IDLE;
      endcase
      if (abort) w_state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_key      <= '0;
         r_bit_cnt  <= '0;
         r_rounds   <= '0;
         r_disc     <= '0;
         r_tamper   <= 1'b0;
         r_exh      <= 1'b0;
         r_basis_a  <= 2'b00;
         r_basis_b  <= 2'b00;
         r_cap_a    <= '0;
         r_cap_b    <= '0;
         r_cap_va   <= 1'b0;
         r_cap_vb   <= 1'b0;
         r_cap_fuse <= 1'b0;
      end else begin
         // Fresh bases are latched on every entry to INIT and held through READ.
         if (w_state_next == INIT && r_state != INIT) begin
            r_basis_a <= w_lfsr_bits[1:0];
            r_basis_b <= w_lfsr_bits[3:2];
         end
         if (abort) begin
            r_key    <= '0;
            r_tamper <= 1'b0;
            r_exh    <= 1'b0;
         end else if (w_start_go) begin
            r_key     <= '0;
            r_bit_cnt <= '0;
            r_rounds  <= '0;
            r_disc    <= '0;
            r_tamper  <= 1'b0;
            r_exh     <= 1'b0;
         end else begin
            case (r_state)
               INIT: r_rounds <= r_rounds + 16'd1;
               READ: begin
                  r_cap_a    <= pair_out_A;
                  r_cap_b    <= pair_out_B;
                  r_cap_va   <= pair_valid_A;
                  r_cap_vb   <= pair_valid_B;
                  r_cap_fuse <= pair_fuse_fire;
               end
               EVAL: begin
                  case (w_sift)
                     KEEP: begin
                        r_key     <= w_key_shift;
                        r_bit_cnt <= w_bit_cnt_keep;
                     end
                     TAMPER: begin
                        r_tamper <= 1'b1;
                        r_key    <= '0;
                     end
                     default: if (r_disc != 16'hFFFF) r_disc <= r_disc + 16'd1;
                  endcase
                  // An exhausted session leaves no partial key behind.
                  if (w_sift != TAMPER && !w_key_full && w_budget_out) begin
                     r_exh <= 1'b1;
                     r_key <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign pair_init     = (r_state == INIT);
   assign pair_read_A   = (r_state == READ);
   assign pair_read_B   = (r_state == READ);
   assign pair_basis_A  = r_basis_a;
   assign pair_basis_B  = r_basis_b;
   assign key           = r_key;
   assign key_valid     = (r_state == DONE);
   assign busy          = (r_state == INIT) || (r_state == SETTLE) ||
                          (r_state == READ) || (r_state == EVAL);
   assign err_tamper    = r_tamper;
   assign err_exhausted = r_exh;
   assign rounds_used   = r_rounds;
   assign discard_count = r_disc;
   assign dbg_status    = {r_cap_fuse, r_state};

endmodule

// File: tb/tb_qkd_pair_sifter.sv
// Bench for qkd_pair_sifter: a queue-fed pair responder, a session-level
// reference model feeding an expected queue, and a negedge monitor.
module tb_qkd_pair_sifter;

   localparam int          KB    = 8;
   localparam int          BPR   = 2;
   localparam int          MR    = 8;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int          EXP_W = KB + 3 + 32;

   logic          clk = 1'b0;
   logic          reset, start, abort;
   logic          pair_init, pair_read_A, pair_read_B;
   logic [1:0]    pair_basis_A, pair_basis_B;
   logic [7:0]    pair_out_A, pair_out_B;
   logic          pair_valid_A, pair_valid_B, pair_fuse_fire;
   logic [KB-1:0] key;
   logic          key_valid, busy, err_tamper, err_exhausted;
   logic [15:0]   rounds_used, discard_count;
   logic [3:0]    dbg_status;

   qkd_pair_sifter #(.KEY_BITS(KB), .BITS_PER_ROUND(BPR), .MAX_ROUNDS(MR), .SEED(SEED)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .pair_init      (pair_init),
      .pair_read_A    (pair_read_A),
      .pair_read_B    (pair_read_B),
      .pair_basis_A   (pair_basis_A),
      .pair_basis_B   (pair_basis_B),
      .pair_out_A     (pair_out_A),
      .pair_out_B     (pair_out_B),
      .pair_valid_A   (pair_valid_A),
      .pair_valid_B   (pair_valid_B),
      .pair_fuse_fire (pair_fuse_fire),
      .key            (key),
      .key_valid      (key_valid),
      .busy           (busy),
      .err_tamper     (err_tamper),
      .err_exhausted  (err_exhausted),
      .rounds_used    (rounds_used),
      .discard_count  (discard_count),
      .dbg_status     (dbg_status)
   );

   always #5 clk = ~clk;

   int                errors = 0;
   int                checks = 0;
   logic [EXP_W-1:0]  exp_q[$];
   logic [17:0]       resp_q[$];
   logic [17:0]       sess[MR];
   int                init_total = 0;
   int                read_total = 0;
   logic [15:0]       m_lfsr = SEED;
   logic [15:0]       m_lfsr_prev = SEED;
   logic [1:0]        exp_ba = 2'b00;
   logic [1:0]        exp_bb = 2'b00;
   logic              prev_end = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Session outcome from the sifting rules, one round at a time.
   function automatic logic [EXP_W-1:0] model_session();
      int key_val = 0;
      int bits = 0;
      int rounds = 0;
      int disc = 0;
      bit done = 0;
      bit tamper = 0;
      bit exh = 0;
      for (int r = 0; r < MR; r++) begin
         if (done || tamper || exh) break;
         rounds++;
         if (sess[r][17] && sess[r][16]) begin
            if (sess[r][15:8] == sess[r][7:0]) begin
               key_val = (key_val * (1 << BPR) + (int'(sess[r][15:8]) % (1 << BPR))) % (1 << KB);
               bits += BPR;
               if (bits == KB) done = 1;
            end else begin
               tamper = 1;
            end
         end else begin
            disc++;
         end
         if (!done && !tamper && rounds == MR) exh = 1;
      end
      if (tamper || exh) key_val = 0;
      return {KB'(key_val), done, tamper, exh, 16'(rounds), 16'(disc)};
   endfunction

   always @(posedge clk) begin
      m_lfsr_prev = m_lfsr;
      if (!reset) m_lfsr = SEED;
      else        m_lfsr = lfsr_step(m_lfsr);
   end

   // Pair responder: each init pulse loads the next scripted read result.
   always @(negedge clk) begin
      if (pair_init) begin
         if (resp_q.size() > 0) begin
            {pair_valid_A, pair_valid_B, pair_out_A, pair_out_B} = resp_q.pop_front();
         end else begin
            pair_valid_A = 1'b0;
            pair_valid_B = 1'b0;
            pair_out_A   = 8'h00;
            pair_out_B   = 8'h00;
         end
         pair_fuse_fire = pair_valid_A ^ pair_valid_B;
      end
   end

   always @(negedge clk) begin
      logic             end_now;
      logic [EXP_W-1:0] e;
      if (pair_init) begin
         init_total++;
         exp_ba = m_lfsr_prev[1:0];
         exp_bb = m_lfsr_prev[3:2];
         check("basis_A_at_init", 64'(pair_basis_A), 64'(exp_ba));
         check("basis_B_at_init", 64'(pair_basis_B), 64'(exp_bb));
      end
      if (pair_read_A || pair_read_B) begin
         read_total++;
         check("read_pair", 64'({pair_read_A, pair_read_B}), 64'(2'b11));
         check("basis_A_held", 64'(pair_basis_A), 64'(exp_ba));
         check("basis_B_held", 64'(pair_basis_B), 64'(exp_bb));
      end
      if (pair_init || pair_read_A || pair_read_B)
         check("init_read_exclusive", 64'(pair_init & (pair_read_A | pair_read_B)), 64'd0);
      end_now = key_valid | err_tamper | err_exhausted;
      if (end_now && !prev_end) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: session ended with no expected entry");
         end else begin
            e = exp_q.pop_front();
            check("key", 64'(key), 64'(e[EXP_W-1 -: KB]));
            check("key_valid", 64'(key_valid), 64'(e[34]));
            check("err_tamper", 64'(err_tamper), 64'(e[33]));
            check("err_exhausted", 64'(err_exhausted), 64'(e[32]));
            check("rounds_used", 64'(rounds_used), 64'(e[31:16]));
            check("discard_count", 64'(discard_count), 64'(e[15:0]));
         end
      end
      prev_end = end_now;
   end

   task automatic run_session(input bit poke_start, input bit check_seed_basis);
      logic [EXP_W-1:0] e;
      logic [15:0]      s;
      int               n_rounds;
      int               cyc;
      bit               ended;
      s = SEED;
      e = model_session();
      n_rounds = int'(e[31:16]);
      for (int r = 0; r < n_rounds; r++) resp_q.push_back(sess[r]);
      exp_q.push_back(e);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("busy_after_start", 64'(busy), 64'd1);
      if (check_seed_basis) begin
         check("first_basis_A_seed", 64'(pair_basis_A), 64'(s[1:0]));
         check("first_basis_B_seed", 64'(pair_basis_B), 64'(s[3:2]));
      end
      ended = 1'b0;
      cyc = 0;
      while (!ended && cyc < 4 * MR + 8) begin
         @(posedge clk);
         cyc++;
         #1 start = (poke_start && cyc == 6);
         @(negedge clk);
         if (cyc == 1) check("rounds_used_first", 64'(rounds_used), 64'd1);
         ended = key_valid | err_tamper | err_exhausted;
      end
      start = 1'b0;
      if (!ended) begin
         checks++;
         errors++;
         $display("FAIL session_timeout: no end after %0d cycles, expected end at %0d", cyc, 4 * n_rounds);
         exp_q.delete();
      end else begin
         check("session_latency", 64'(cyc), 64'(4 * n_rounds));
      end
      resp_q.delete();
   endtask

   initial begin
      int base;
      logic [7:0] a;
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      pair_out_A = 8'h00;
      pair_out_B = 8'h00;
      pair_valid_A = 1'b0;
      pair_valid_B = 1'b0;
      pair_fuse_fire = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_key", 64'(key), 64'd0);
      check("rst_flags", 64'({key_valid, busy, err_tamper, err_exhausted}), 64'd0);
      check("rst_strobes", 64'({pair_init, pair_read_A, pair_read_B}), 64'd0);
      check("rst_bases", 64'({pair_basis_A, pair_basis_B}), 64'd0);
      check("rst_counters", 64'({rounds_used, discard_count}), 64'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Every round agrees on 8'h5B: two key bits 2'b11 per round.
      for (int r = 0; r < MR; r++) sess[r] = {2'b11, 8'h5B, 8'h5B};
      run_session(1'b0, 1'b0);
      check("t1_key_ff", 64'(key), 64'hFF);
      check("t1_rounds", 64'(rounds_used), 64'd4);

      // A-only rounds interleaved with agreeing 8'h02 rounds; start poked mid-session.
      for (int r = 0; r < MR; r++)
         sess[r] = (r % 2 == 0) ? {2'b10, 8'h02, 8'h02} : {2'b11, 8'h02, 8'h02};
      run_session(1'b1, 1'b0);
      check("t2_key_aa", 64'(key), 64'hAA);
      check("t2_done_not_exhausted", 64'({key_valid, err_exhausted}), 64'(2'b10));
      check("t2_discards", 64'(discard_count), 64'd4);

      // abort together with start in DONE returns to IDLE.
      @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("abort_beats_start", 64'({busy, key_valid, pair_init}), 64'd0);
      check("abort_clears_key", 64'(key), 64'd0);

      // Tamper on the first round: ERROR, key zero, no further rounds.
      for (int r = 0; r < MR; r++) sess[r] = {2'b11, 8'h11, 8'h10};
      run_session(1'b0, 1'b0);
      base = init_total;
      repeat (12) @(negedge clk);
      check("t3_no_init_after_error", 64'(init_total - base), 64'd0);
      check("t3_key_zero", 64'(key), 64'd0);
      check("t3_tamper_sticky", 64'(err_tamper), 64'd1);

      // Never valid: budget runs out after MR rounds.
      for (int r = 0; r < MR; r++) sess[r] = {2'b00, 8'h33, 8'h44};
      base = init_total;
      run_session(1'b0, 1'b0);
      check("t4_init_pulses", 64'(init_total - base), 64'(MR));

      // abort in SETTLE of round 2.
      base = read_total;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("t5_idle_after_abort", 64'({busy, pair_read_A, pair_init}), 64'd0);
      check("t5_one_read_only", 64'(read_total - base), 64'd1);
      check("t5_key_errs_clear", 64'({key, err_tamper, err_exhausted}), 64'd0);
      for (int r = 0; r < MR; r++) sess[r] = {2'b11, 8'h5B, 8'h5B};
      run_session(1'b0, 1'b0);

      // Reset asserted while in READ.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_in_read", 64'(pair_read_A), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check("t6_strobes_low", 64'({pair_init, pair_read_A, pair_read_B, busy}), 64'd0);
      check("t6_key_zero", 64'(key), 64'd0);
      reset = 1'b1;
      run_session(1'b0, 1'b1);

      // Randomised sessions.
      for (int s = 0; s < 10; s++) begin
         for (int r = 0; r < MR; r++) begin
            a = 8'($urandom_range(0, 255));
            sess[r] = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), a,
                       ($urandom_range(0, 9) == 0) ? (a ^ 8'h01) : a};
         end
         run_session(1'b0, 1'b0);
      end

      repeat (2) @(negedge clk);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
